// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN for strict r0 priority on ties.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  r0_req_valid_i,
  output logic                  r0_req_ready_o,
  input  logic [CTRL_WIDTH-1:0] r0_ctrl_i,
  input  logic [DATA_WIDTH-1:0] r0_a_i,
  input  logic [DATA_WIDTH-1:0] r0_b_i,
  output logic                  r0_rsp_valid_o,
  input  logic                  r0_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] r0_rsp_result_o,
  output logic [3:0]            r0_rsp_flags_o,
  input  logic                  r1_req_valid_i,
  output logic                  r1_req_ready_o,
  input  logic [CTRL_WIDTH-1:0] r1_ctrl_i,
  input  logic [DATA_WIDTH-1:0] r1_a_i,
  input  logic [DATA_WIDTH-1:0] r1_b_i,
  output logic                  r1_rsp_valid_o,
  input  logic                  r1_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] r1_rsp_result_o,
  output logic [3:0]            r1_rsp_flags_o,
  output logic [CTRL_WIDTH-1:0] alu_control_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [3:0]            alu_flags_i,
  output logic [15:0]           grant_cnt0_o,
  output logic [15:0]           grant_cnt1_o
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [1:0] req_valid;
  logic [1:0] rsp_ready;
  logic [1:0] elig;
  logic [1:0] gnt;

  logic [1:0]                 rsp_valid_q, rsp_valid_d;
  logic [1:0][DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [1:0][3:0]            rsp_flags_q, rsp_flags_d;
  logic [1:0][15:0]           grant_cnt_q, grant_cnt_d;
  logic                       last_grant_q, last_grant_d;

  assign req_valid = {r1_req_valid_i, r0_req_valid_i};
  assign rsp_ready = {r1_rsp_ready_i, r0_rsp_ready_i};

  // A full buffer only blocks its own requester, and only if not draining.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (elig == 2'b11): gnt = last_grant_q ? 2'b01 : 2'b10;
      (elig == 2'b01): gnt = 2'b01;
      (elig == 2'b10): gnt = 2'b10;
      default:         gnt = 2'b00;
    endcase
  end

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`else
    last_grant_d = (|gnt) ? gnt[1] : last_grant_q;
`endif
  end

  always_comb begin
    alu_control_o = '0;
    alu_a_o       = '0;
    alu_b_o       = '0;
    unique case (1'b1)
      gnt[0]: begin
        alu_control_o = r0_ctrl_i;
        alu_a_o       = r0_a_i;
        alu_b_o       = r0_b_i;
      end
      gnt[1]: begin
        alu_control_o = r1_ctrl_i;
        alu_a_o       = r1_a_i;
        alu_b_o       = r1_b_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    grant_cnt_d  = grant_cnt_q;
    for (int n = 0; n < 2; n++) begin
      rsp_valid_d[n] = gnt[n] |
                       (rsp_valid_q[n] & ~rsp_ready[n]);
      if (gnt[n]) begin
        rsp_result_d[n] = alu_result_i;
        rsp_flags_d[n]  = alu_flags_i;
      end
      if (gnt[n] && grant_cnt_q[n] != CNT_MAX) begin
        grant_cnt_d[n] = grant_cnt_q[n] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      grant_cnt_q  <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      grant_cnt_q  <= grant_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign r0_req_ready_o  = gnt[0];
  assign r1_req_ready_o  = gnt[1];
  assign r0_rsp_valid_o  = rsp_valid_q[0];
  assign r1_rsp_valid_o  = rsp_valid_q[1];
  assign r0_rsp_result_o = rsp_result_q[0];
  assign r1_rsp_result_o = rsp_result_q[1];
  assign r0_rsp_flags_o  = rsp_flags_q[0];
  assign r1_rsp_flags_o  = rsp_flags_q[1];
  assign grant_cnt0_o    = grant_cnt_q[0];
  assign grant_cnt1_o    = grant_cnt_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: random two-requester traffic with a queue scoreboard.
// A behavioural ALU stub feeds the DUT; responses are checked by a monitor.
module tb_alu_share_arbiter;
  localparam int W = 32;
  localparam int C = 4;

  logic clk;
  logic reset_i;

  logic [1:0]   req_v;
  logic [1:0]   rsp_r;
  logic [C-1:0] rc [2];
  logic [W-1:0] ra [2];
  logic [W-1:0] rb [2];

  logic         r0_req_ready_o, r1_req_ready_o;
  logic         r0_rsp_valid_o, r1_rsp_valid_o;
  logic [W-1:0] r0_rsp_result_o, r1_rsp_result_o;
  logic [3:0]   r0_rsp_flags_o, r1_rsp_flags_o;
  logic [C-1:0] alu_control_o;
  logic [W-1:0] alu_a_o, alu_b_o;
  logic [W-1:0] alu_result_i;
  logic [3:0]   alu_flags_i;
  logic [15:0]  grant_cnt0_o, grant_cnt1_o;

  alu_share_arbiter #(.DATA_WIDTH(W), .CTRL_WIDTH(C)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .r0_req_valid_i  (req_v[0]),
    .r0_req_ready_o  (r0_req_ready_o),
    .r0_ctrl_i       (rc[0]),
    .r0_a_i          (ra[0]),
    .r0_b_i          (rb[0]),
    .r0_rsp_valid_o  (r0_rsp_valid_o),
    .r0_rsp_ready_i  (rsp_r[0]),
    .r0_rsp_result_o (r0_rsp_result_o),
    .r0_rsp_flags_o  (r0_rsp_flags_o),
    .r1_req_valid_i  (req_v[1]),
    .r1_req_ready_o  (r1_req_ready_o),
    .r1_ctrl_i       (rc[1]),
    .r1_a_i          (ra[1]),
    .r1_b_i          (rb[1]),
    .r1_rsp_valid_o  (r1_rsp_valid_o),
    .r1_rsp_ready_i  (rsp_r[1]),
    .r1_rsp_result_o (r1_rsp_result_o),
    .r1_rsp_flags_o  (r1_rsp_flags_o),
    .alu_control_o   (alu_control_o),
    .alu_a_o         (alu_a_o),
    .alu_b_o         (alu_b_o),
    .alu_result_i    (alu_result_i),
    .alu_flags_i     (alu_flags_i),
    .grant_cnt0_o    (grant_cnt0_o),
    .grant_cnt1_o    (grant_cnt1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+3:0] alu_fn(
    input logic [C-1:0] c,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] r;
    case (c[1:0])
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a & b;
      default: r = a ^ b;
    endcase
    return {r[W-1], (r == '0), a[W-1] ^ b[W-1], ^r, r};
  endfunction

  always_comb {alu_flags_i, alu_result_i} =
    alu_fn(alu_control_o, alu_a_o, alu_b_o);

  logic [1:0]   rdy;
  logic [1:0]   rsp_v;
  logic [W+3:0] rsp_d [2];
  assign rdy      = {r1_req_ready_o, r0_req_ready_o};
  assign rsp_v    = {r1_rsp_valid_o, r0_rsp_valid_o};
  assign rsp_d[0] = {r0_rsp_flags_o, r0_rsp_result_o};
  assign rsp_d[1] = {r1_rsp_flags_o, r1_rsp_result_o};

  int checks = 0;
  int errors = 0;
  bit started = 0;

  logic [W+3:0] q0 [$];
  logic [W+3:0] q1 [$];
  logic [W+3:0] last_d [2];
  logic [1:0]   occ;
  logic [1:0]   last_g;
  int           cntm [2];
  int           last_w;
  int           pv [2];
  int           pr [2];

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin : monitor
    logic [W+3:0] e;
    bit ok;
    if (started && !reset_i) begin
      for (int n = 0; n < 2; n++) begin
        if (rsp_v[n] && rsp_r[n]) begin
          ok = 0;
          e  = '0;
          if (n == 0 && q0.size() > 0) begin ok = 1; e = q0.pop_front(); end
          if (n == 1 && q1.size() > 0) begin ok = 1; e = q1.pop_front(); end
          if (ok) begin
            chk($sformatf("rsp_data%0d", n), 64'(rsp_d[n]), 64'(e));
            last_d[n] = e;
          end else begin
            checks++;
            errors++;
            $display("FAIL rsp_extra%0d act=valid exp=empty", n);
          end
        end else if (!rsp_v[n]) begin
          chk($sformatf("rsp_hold%0d", n), 64'(rsp_d[n]), 64'(last_d[n]));
        end
      end
    end
  end

  task automatic drive();
    for (int n = 0; n < 2; n++) begin
      if (!(req_v[n] && !last_g[n])) begin
        req_v[n] = ($urandom_range(99) < pv[n]);
        rc[n]    = 4'($urandom_range(15));
        ra[n]    = $urandom;
        rb[n]    = ($urandom_range(3) == 0) ? ra[n] : $urandom;
      end
      rsp_r[n] = ($urandom_range(99) < pr[n]);
    end
  endtask

  task automatic check_cycle();
    logic [1:0]   e, g;
    logic [C-1:0] ec;
    logic [W-1:0] ea, eb;
    e = req_v & (~occ | rsp_r);
    if (e == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 2'b01;
`else
      g = (last_w == 1) ? 2'b01 : 2'b10;
`endif
    end else begin
      g = e;
    end
    ec = '0;
    ea = '0;
    eb = '0;
    for (int n = 0; n < 2; n++) begin
      if (g[n]) begin
        ec = rc[n];
        ea = ra[n];
        eb = rb[n];
      end
    end
    chk("grant", 64'(rdy), 64'(g));
    chk("alu_ctrl", 64'(alu_control_o), 64'(ec));
    chk("alu_a", 64'(alu_a_o), 64'(ea));
    chk("alu_b", 64'(alu_b_o), 64'(eb));
    chk("rsp_valid", 64'(rsp_v), 64'(occ));
    chk("cnt0", 64'(grant_cnt0_o), 64'(cntm[0]));
    chk("cnt1", 64'(grant_cnt1_o), 64'(cntm[1]));
    for (int n = 0; n < 2; n++) begin
      if (g[n]) begin
        if (n == 0) q0.push_back(alu_fn(rc[n], ra[n], rb[n]));
        else        q1.push_back(alu_fn(rc[n], ra[n], rb[n]));
        if (cntm[n] < 65535) cntm[n]++;
      end
      occ[n] = g[n] | (occ[n] & ~rsp_r[n]);
    end
    if (g != 2'b00) last_w = g[1] ? 1 : 0;
    last_g = g;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    q0.delete();
    q1.delete();
    occ       = '0;
    cntm[0]   = 0;
    cntm[1]   = 0;
    last_w    = 1;
    last_d[0] = '0;
    last_d[1] = '0;
    last_g    = '0;
  endtask

  initial begin
    int exp0, exp1;
    reset_i = 1'b1;
    req_v   = '0;
    rsp_r   = '0;
    for (int n = 0; n < 2; n++) begin
      rc[n] = '0;
      ra[n] = '0;
      rb[n] = '0;
      pv[n] = 0;
      pr[n] = 0;
    end
    @(posedge clk);
    #1;
    do_reset();
    started = 1;

    // T6 then T1: idle, then a single r0 add
    run(3);
    req_v[0] = 1'b1;
    rc[0]    = 4'h0;
    ra[0]    = 32'd5;
    rb[0]    = 32'd7;
    @(negedge clk);
    chk("t1_ready", 64'(r0_req_ready_o), 64'd1);
    chk("t1_alu_a", 64'(alu_a_o), 64'd5);
    chk("t1_alu_b", 64'(alu_b_o), 64'd7);
    check_cycle();
    @(posedge clk);
    #1;
    req_v[0] = 1'b0;
    rsp_r[0] = 1'b1;
    @(negedge clk);
    chk("t1_rsp_valid", 64'(r0_rsp_valid_o), 64'd1);
    chk("t1_result", 64'(r0_rsp_result_o), 64'd12);
    chk("t1_flags", 64'(r0_rsp_flags_o), 64'd0);
    check_cycle();
    @(posedge clk);
    #1;

    // T2: both requesting every cycle, both draining
    do_reset();
    pv = '{100, 100};
    pr = '{100, 100};
    run(8);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp0 = 8;
    exp1 = 0;
`else
    exp0 = 4;
    exp1 = 4;
`endif
    chk("t2_cnt0", 64'(grant_cnt0_o), 64'(exp0));
    chk("t2_cnt1", 64'(grant_cnt1_o), 64'(exp1));

    // T3: r1 stalled on a full buffer
    pr = '{100, 0};
    run(20);

    // T5: reset while r0 drains and reloads
    pr = '{100, 100};
    run(4);
    do_reset();
    run(4);

    for (int ph = 0; ph < 14; ph++) begin
      pv[0] = $urandom_range(100);
      pv[1] = $urandom_range(100);
      pr[0] = (ph % 4 == 1) ? 0 : $urandom_range(100);
      pr[1] = (ph % 4 == 2) ? 0 : $urandom_range(100);
      run(200);
      if (ph % 3 == 2) do_reset();
    end

    pv = '{0, 0};
    pr = '{100, 100};
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
